// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Size codes, FSM states, byte-lane mask and load extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Size code 2'b11 falls into the word branches below.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << addr_lo;
            SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_lanes(
        input logic [31:0] wdata,
        input logic [1:0]  size
    );
        logic [31:0] v;
        case (size)
            SZ_BYTE: v = {4{wdata[7:0]}};
            SZ_HALF: v = {2{wdata[15:0]}};
            default: v = wdata;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  addr_lo,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: v = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: v = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: v = word;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word storage: synchronous write, combinational read.
// Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with pipeline stall output.
// DMEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses via err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        stall,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    state_e        r_state;
    state_e        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;

    logic [31:2]   w_offset;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lo;
    logic          w_misalign;
    logic          w_last;
    logic          w_ok;
    logic          w_we;
    logic [31:0]   w_rword;
    logic [31:0]   w_rdata;

    // Unsigned subtraction makes addresses below the base wrap out of range.
    assign w_offset   = r_addr[31:2] - BASE_ADDR[31:2];
    assign w_in_range = (w_offset[31:AW+2] == '0);
    assign w_idx      = w_offset[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_lo       = r_addr[1:0];
    assign w_misalign = (r_size == SZ_HALF && r_addr[0])
                      | (r_size[1] && r_addr[1:0] != 2'b00);
`else
    assign w_lo       = r_size[1] ? 2'b00
                      : (r_size == SZ_HALF) ? {r_addr[1], 1'b0}
                      : r_addr[1:0];
    assign w_misalign = 1'b0;
`endif

    assign w_last  = (r_state == ST_WAIT) && (r_cnt == CW'(1));
    assign w_ok    = w_in_range & ~w_misalign;
    assign w_we    = w_last & r_write & w_ok & ~reset;
    assign w_rdata = (r_write | ~w_ok) ? 32'h0
                   : load_extend(w_rword, r_size, w_lo, r_unsigned);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (lane_mask(r_size, w_lo)),
        .i_idx   (w_idx),
        .i_wdata (store_lanes(r_wdata, r_size)),
        .o_rdata (w_rword)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (r_cnt == CW'(1)) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_rsp_valid <= w_last;
            r_rsp_rdata <= w_last ? w_rdata : 32'h0;
            if (r_state == ST_IDLE && req_valid) begin
                r_cnt <= CW'(LATENCY);
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Request fields are captured once; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset && r_state == ST_IDLE && req_valid) begin
            r_write    <= req_write;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_err;
    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= w_last & w_misalign;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus
// randomized traffic against a byte-addressed reference memory.
module tb_dmem_responder;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          WIN   = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        stall;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mb [WIN];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .stall        (stall),
        .err          (err)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drives one request; reports data, err, response delay, stall cycles
    // and req_ready at accept and on the cycle after the response.
    task automatic access(
        input  logic        w,
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  logic [1:0]  sz,
        input  logic        u,
        output logic [31:0] rd,
        output logic        e,
        output int          lat,
        output int          stl,
        output logic        rdy0,
        output logic        rdy1
    );
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a;
        req_wdata = d; req_size = sz; req_unsigned = u;
        #1;
        rdy0 = req_ready;
        stl  = stall ? 1 : 0;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        lat = 0; rd = 32'h0; e = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (stall) stl++;
            if (rsp_valid) begin
                lat = i; rd = rsp_rdata; e = err;
                break;
            end
        end
        @(negedge clk);
        rdy1 = req_ready && !rsp_valid;
    endtask

    // Reference: byte-addressed memory window, plain arithmetic extension.
    function automatic logic [32:0] model(
        input logic        w,
        input logic [31:0] a,
        input logic [31:0] d,
        input logic [1:0]  sz,
        input logic        u
    );
        logic [31:0] off;
        logic [31:0] v;
        logic        mis;
        int          n;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = a - BASE;
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (mis) return {1'b1, 32'h0};
`else
        if (mis) off = off - (off % n);
`endif
        if (off >= 4 * DEPTH) return 33'h0;
        if (w) begin
            for (int i = 0; i < n; i++) mb[off + i] = d[8*i +: 8];
            return 33'h0;
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[off + i];
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return {1'b0, v};
    endfunction

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'd0;
        req_unsigned = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid);
        end
        n_cmp++;
        if (rsp_rdata !== 32'h0) begin
            n_bad++; $display("FAIL rst_rdata got %h want 0", rsp_rdata);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL rst_err got %b want 0", err);
        end
        n_cmp++;
        if (stall !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_idle got stall=%b ready=%b want 0/1",
                     stall, req_ready);
        end
        req_valid = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL rst_stall_follows got %b want 1", stall);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || stall !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_priority got ready=%b stall=%b want 1/1",
                     req_ready, stall);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic e, r0, r1; int lat, stl;
        access(1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 2'd2, 1'b0,
               rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (lat !== LAT + 1 || stl !== LAT + 1) begin
            n_bad++;
            $display("FAIL sw_timing got lat=%0d stall=%0d want %0d/%0d",
                     lat, stl, LAT + 1, LAT + 1);
        end
        n_cmp++;
        if (rd !== 32'h0 || r0 !== 1'b1 || r1 !== 1'b1) begin
            n_bad++;
            $display("FAIL sw_rsp got rd=%h rdy=%b%b want 0 rdy=11",
                     rd, r0, r1);
        end
        access(1'b0, 32'h0001_0010, 32'h0, 2'd2, 1'b0,
               rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL lw_data got %h want deadbeef", rd);
        end
        n_cmp++;
        if (lat !== LAT + 1 || stl !== LAT + 1 || r1 !== 1'b1) begin
            n_bad++;
            $display("FAIL lw_timing got lat=%0d stall=%0d rdy=%b want %0d/%0d/1",
                     lat, stl, r1, LAT + 1, LAT + 1);
        end
    endtask

    task automatic test_extension();
        logic [31:0] rd; logic e, r0, r1; int lat, stl;
        access(1'b1, 32'h0001_0020, 32'h80FF_7F01, 2'd2, 1'b0,
               rd, e, lat, stl, r0, r1);
        access(1'b0, 32'h0001_0023, 32'h0, 2'd0, 1'b0,
               rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (rd !== 32'hFFFF_FF80) begin
            n_bad++; $display("FAIL lb_sign got %h want ffffff80", rd);
        end
        access(1'b0, 32'h0001_0023, 32'h0, 2'd0, 1'b1,
               rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (rd !== 32'h0000_0080) begin
            n_bad++; $display("FAIL lbu_zero got %h want 00000080", rd);
        end
        access(1'b0, 32'h0001_0020, 32'h0, 2'd0, 1'b0,
               rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (rd !== 32'h0000_0001) begin
            n_bad++; $display("FAIL lb_lane0 got %h want 00000001", rd);
        end
    endtask

    task automatic test_half_lane();
        logic [31:0] rd; logic e, r0, r1; int lat, stl;
        access(1'b1, 32'h0001_0022, 32'hABCD_1234, 2'd1, 1'b0,
               rd, e, lat, stl, r0, r1);
        access(1'b0, 32'h0001_0020, 32'h0, 2'd2, 1'b0,
               rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (rd !== 32'h1234_7F01) begin
            n_bad++; $display("FAIL sh_lanes got %h want 12347f01", rd);
        end
        access(1'b0, 32'h0001_0022, 32'h0, 2'd1, 1'b0,
               rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (rd !== 32'h0000_1234) begin
            n_bad++; $display("FAIL lh_upper got %h want 00001234", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic e, r0, r1; int lat, stl;
        logic [31:0] top;
        top = BASE + 4 * DEPTH;
        access(1'b1, BASE, 32'h1111_1111, 2'd2, 1'b0,
               rd, e, lat, stl, r0, r1);
        access(1'b1, 32'h0, 32'hA5A5_A5A5, 2'd2, 1'b0,
               rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (lat !== LAT + 1 || stl !== LAT + 1) begin
            n_bad++;
            $display("FAIL oor_st_timing got lat=%0d stall=%0d want %0d",
                     lat, stl, LAT + 1);
        end
        access(1'b1, top, 32'h5A5A_5A5A, 2'd2, 1'b0,
               rd, e, lat, stl, r0, r1);
        access(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (rd !== 32'h0 || lat !== LAT + 1) begin
            n_bad++;
            $display("FAIL oor_ld_low got %h lat=%0d want 0 lat=%0d",
                     rd, lat, LAT + 1);
        end
        access(1'b0, top, 32'h0, 2'd2, 1'b0, rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_bad++; $display("FAIL oor_ld_high got %h want 0", rd);
        end
        access(1'b0, BASE, 32'h0, 2'd2, 1'b0, rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (rd !== 32'h1111_1111) begin
            n_bad++; $display("FAIL oor_alias got %h want 11111111", rd);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic e, r0, r1; int lat, stl;
        logic seen, rdy;
        access(1'b1, 32'h0001_0040, 32'h0, 2'd2, 1'b0,
               rd, e, lat, stl, r0, r1);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0001_0040;
        req_wdata = 32'hCAFE_F00D; req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) rdy = req_ready;
            if (rsp_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL rst_wait_rsp got pulse=%b want 0", seen);
        end
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_bad++; $display("FAIL rst_wait_ready got %b want 1", rdy);
        end
        access(1'b0, 32'h0001_0040, 32'h0, 2'd2, 1'b0,
               rd, e, lat, stl, r0, r1);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_bad++; $display("FAIL rst_wait_drop got %h want 0", rd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic e, r0, r1; int lat, stl;
        logic [31:0] exp_d; logic exp_e;
        access(1'b1, 32'h0001_0040, 32'h1357_9BDF, 2'd2, 1'b0,
               rd, e, lat, stl, r0, r1);
        access(1'b0, 32'h0001_0042, 32'h0, 2'd2, 1'b0,
               rd, e, lat, stl, r0, r1);
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_d = 32'h0; exp_e = 1'b1;
`else
        exp_d = 32'h1357_9BDF; exp_e = 1'b0;
`endif
        n_cmp++;
        if (rd !== exp_d || e !== exp_e || lat !== LAT + 1) begin
            n_bad++;
            $display("FAIL misalign_lw got %h err=%b lat=%0d want %h err=%b lat=%0d",
                     rd, e, lat, exp_d, exp_e, LAT + 1);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic e, r0, r1; int lat, stl;
        logic [31:0] a, d; logic [1:0] sz; logic w, u;
        logic [32:0] exp;
        for (int i = 0; i < WIN; i += 4) begin
            d = $urandom;
            void'(model(1'b1, BASE + 32'(i), d, 2'd2, 1'b0));
            access(1'b1, BASE + 32'(i), d, 2'd2, 1'b0,
                   rd, e, lat, stl, r0, r1);
        end
        for (int k = 0; k < 200; k++) begin
            w  = 1'($urandom);
            u  = 1'($urandom);
            sz = 2'($urandom);
            d  = $urandom;
            case ($urandom_range(0, 15))
                0:       a = 32'h0 + 32'($urandom_range(0, 15));
                1:       a = BASE - 32'($urandom_range(1, 8));
                2:       a = BASE + 4 * DEPTH + 32'($urandom_range(0, 15));
                default: a = BASE + 32'($urandom_range(0, WIN - 1));
            endcase
            exp = model(w, a, d, sz, u);
            access(w, a, d, sz, u, rd, e, lat, stl, r0, r1);
            n_cmp++;
            if (rd !== exp[31:0] || e !== exp[32]) begin
                n_bad++;
                $display("FAIL rnd_%0d w=%b a=%h sz=%0d u=%b got %h/%b want %h/%b",
                         k, w, a, sz, u, rd, e, exp[31:0], exp[32]);
            end
            n_cmp++;
            if (lat !== LAT + 1 || stl !== LAT + 1 || r0 !== 1'b1
                || r1 !== 1'b1) begin
                n_bad++;
                $display("FAIL rnd_timing_%0d got lat=%0d stall=%0d rdy=%b%b",
                         k, lat, stl, r0, r1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extension();
        test_half_lane();
        test_out_of_range();
        test_reset_mid_wait();
        test_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
